// File: rtl/sap_1_controller.sv
// SAP-1 control sequencer.
//
// A six-state one-hot ring counter (T1..T6) steps through the fetch and
// execute phases of each instruction. The control word is decoded
// combinationally from the current T-state and the opcode.
//
// Ports:
//   clk      - system clock; all state changes on the rising edge
//   clr_n    - synchronous active-low reset; also forces controls inactive
//   opcode   - instruction register upper nibble, used during T4..T6
//   cp, ep   - PC increment / PC to bus (active-high)
//   lm_n     - MAR load (active-low)
//   ce_n     - memory to bus (active-low)
//   li_n     - IR load (active-low)
//   ei_n     - IR operand nibble to bus (active-low)
//   la_n     - accumulator load (active-low)
//   ea       - accumulator to bus (active-high)
//   su, eu   - ALU subtract select / ALU to bus (active-high)
//   lb_n     - B register load (active-low)
//   lo_n     - output register load (active-low)
//   t_state  - one-hot ring state, bit0 = T1 .. bit5 = T6
//   halted   - set once HLT has executed; cleared only by reset
module sap_1_controller (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm_n,
    output logic       ce_n,
    output logic       li_n,
    output logic       ei_n,
    output logic       la_n,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb_n,
    output logic       lo_n,
    output logic [5:0] t_state,
    output logic       halted
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } op_e;

    tstate_e state, state_next;
    logic    halted_next;
    op_e     op;

    assign op      = op_e'(opcode);
    assign t_state = state;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state  <= T1;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    // HLT freezes the ring in T4 rather than letting it advance.
    always_comb begin
        state_next  = state;
        halted_next = halted;
        if (!halted) begin
            case (state)
                T1: state_next = T2;
                T2: state_next = T3;
                T3: state_next = T4;
                T4: begin
                    if (op == OP_HLT) halted_next = 1'b1;
                    else              state_next  = T5;
                end
                T5: state_next = T6;
                T6: state_next = T1;
                default: state_next = T1;
            endcase
        end
    end

    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        lm_n = 1'b1;
        ce_n = 1'b1;
        li_n = 1'b1;
        ei_n = 1'b1;
        la_n = 1'b1;
        ea   = 1'b0;
        su   = 1'b0;
        eu   = 1'b0;
        lb_n = 1'b1;
        lo_n = 1'b1;
        if (clr_n && !halted) begin
            case (state)
                T1: begin
                    ep   = 1'b1;
                    lm_n = 1'b0;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce_n = 1'b0;
                    li_n = 1'b0;
                end
                T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ei_n = 1'b0;
                            lm_n = 1'b0;
                        end
                        OP_OUT: begin
                            ea   = 1'b1;
                            lo_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA: begin
                            ce_n = 1'b0;
                            la_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ce_n = 1'b0;
                            lb_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            eu   = 1'b1;
                            la_n = 1'b0;
                            su   = (op == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_1_controller.sv
// Self-checking bench for sap_1_controller: directed sequences plus random
// opcode/reset stimulus, checked against an instruction-level model through
// an expected-value queue.
module tb_sap_1_controller;

    typedef struct packed {
        logic       cp;
        logic       ep;
        logic       lm_n;
        logic       ce_n;
        logic       li_n;
        logic       ei_n;
        logic       la_n;
        logic       ea;
        logic       su;
        logic       eu;
        logic       lb_n;
        logic       lo_n;
        logic [5:0] t;
        logic       halted;
    } obs_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
    logic [5:0] t_state;
    logic       halted;

    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];

    // Model state: step number 1..6 of the instruction, and halt flag.
    int   m_step = 1;
    bit   m_halt = 1'b0;

    sap_1_controller dut (
        .clk(clk), .clr_n(clr_n), .opcode(opcode),
        .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n),
        .ei_n(ei_n), .la_n(la_n), .ea(ea), .su(su), .eu(eu),
        .lb_n(lb_n), .lo_n(lo_n), .t_state(t_state), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_out(int step, bit hlt, bit clr, logic [3:0] op);
        obs_t r;
        bit   mem_op;
        bit   alu_op;
        r = '0;
        r.lm_n = 1'b1; r.ce_n = 1'b1; r.li_n = 1'b1; r.ei_n = 1'b1;
        r.la_n = 1'b1; r.lb_n = 1'b1; r.lo_n = 1'b1;
        r.t      = 6'(1 << (step - 1));
        r.halted = hlt;
        alu_op = (op == 4'd1) || (op == 4'd2);
        mem_op = (op == 4'd0) || alu_op;
        if (clr && !hlt) begin
            if (step == 1) begin r.ep = 1'b1; r.lm_n = 1'b0; end
            if (step == 2) r.cp = 1'b1;
            if (step == 3) begin r.ce_n = 1'b0; r.li_n = 1'b0; end
            if (step == 4 && mem_op) begin r.ei_n = 1'b0; r.lm_n = 1'b0; end
            if (step == 4 && op == 4'd14) begin r.ea = 1'b1; r.lo_n = 1'b0; end
            if (step == 5 && mem_op) r.ce_n = 1'b0;
            if (step == 5 && op == 4'd0) r.la_n = 1'b0;
            if (step == 5 && alu_op) r.lb_n = 1'b0;
            if (step == 6 && alu_op) begin
                r.eu = 1'b1; r.la_n = 1'b0; r.su = (op == 4'd2);
            end
        end
        return r;
    endfunction

    // Apply inputs for one cycle, record the expected response, advance the model.
    task automatic drive(input logic [3:0] op, input bit clr);
        opcode = op;
        clr_n  = clr;
        exp_q.push_back(model_out(m_step, m_halt, clr, op));
        if (!clr) begin
            m_step = 1;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 4 && op == 4'd15) m_halt = 1'b1;
            else m_step = (m_step % 6) + 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents a control word every cycle.
    always @(negedge clk) begin
        obs_t act;
        obs_t e;
        int   drivers;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = '{cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, t_state, halted};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%h expected=%h", $time, act, e);
            end
            drivers = int'(ep) + int'(!ce_n) + int'(!ei_n) + int'(ea) + int'(eu);
            checks++;
            if (drivers > 1) begin
                errors++;
                $display("FAIL bus_drivers t=%0t actual=%0d expected<=1", $time, drivers);
            end
        end
    end

    initial begin
        // Initial reset edge; the model starts at T1, not halted.
        clr_n  = 1'b0;
        opcode = 4'd0;
        @(posedge clk);
        #1;
        m_step = 1;
        m_halt = 1'b0;
        drive(4'd0, 1'b0);

        // LDA for two full instruction cycles.
        for (int i = 0; i < 12; i++) drive(4'd0, 1'b1);

        // Sweep every opcode for one instruction; HLT then holds for 20 clocks.
        for (int op = 0; op < 16; op++) begin
            for (int i = 0; i < 6; i++) drive(4'(op), 1'b1);
        end
        for (int i = 0; i < 20; i++) drive(4'(i), 1'b1);
        drive(4'd15, 1'b0);

        // ADD aborted by reset during T5.
        for (int i = 0; i < 4; i++) drive(4'd1, 1'b1);
        drive(4'd1, 1'b0);
        for (int i = 0; i < 6; i++) drive(4'd1, 1'b1);

        // Random opcodes with occasional resets; HLT eventually cleared by reset.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            bit         clr;
            op  = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 24) != 0);
            drive(op, clr);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
